// File: rtl/tdm_demux_check.sv
// tdm_demux_check: splits a two-slot TDM stream into (A, B) pairs, checks A/B complement and
// framing, and counts errors with a saturating counter.
module tdm_demux_check #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 z,
    input  logic                 in_valid,
    input  logic                 sync,
    input  logic                 out_ready,
    output logic                 sel,
    output logic                 a_out,
    output logic                 b_out,
    output logic                 out_valid,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 overflow
);
    typedef enum logic [1:0] {HUNT, SLOT_A, SLOT_B} state_t;
    state_t state, state_nx;
    logic pend_a, take_a, complete, misalign, load, drop, err_ev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HUNT;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (in_valid)
            case (state)
                HUNT:    state_nx = sync ? SLOT_B : HUNT;
                SLOT_A:  state_nx = SLOT_B;
                SLOT_B:  state_nx = sync ? SLOT_B : SLOT_A;
                default: state_nx = HUNT;
            endcase
    end
    // A sync inside SLOT_B restarts the frame, so any sync sample is taken as a fresh A.
    always_comb begin
        sel      = state != SLOT_B;
        take_a   = in_valid && (state == SLOT_A || sync);
        complete = in_valid && state == SLOT_B && !sync;
        misalign = in_valid && state == SLOT_B && sync;
        load     = complete && (!out_valid || out_ready);
        drop     = complete && out_valid && !out_ready;
        err_ev   = misalign || (load && pend_a == z);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_a    <= 1'b0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (take_a) pend_a <= z;
            if (load) begin
                a_out <= pend_a;
                b_out <= z;
            end
            out_valid <= load || (out_valid && !out_ready);
            overflow  <= overflow || drop;
            err       <= err_ev;
            if (err_ev && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_tdm_demux_check.sv
// tb_tdm_demux_check: directed vector table for tdm_demux_check, run on an 8-bit and a 2-bit
// error-counter instance driven by the same stimulus.
module tb_tdm_demux_check;
    logic clk = 1'b0, rst_n = 1'b0, z = 1'b0, in_valid = 1'b0, sync = 1'b0, out_ready = 1'b1;
    logic sel8, a8, b8, ov8, e8, ovf8;
    logic sel2, a2, b2, ov2, e2, ovf2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    int nvec = 0, nmis = 0;

    always #5 clk = ~clk;

    tdm_demux_check u8 (
        .clk(clk), .rst_n(rst_n), .z(z), .in_valid(in_valid), .sync(sync), .out_ready(out_ready),
        .sel(sel8), .a_out(a8), .b_out(b8), .out_valid(ov8), .err(e8), .err_cnt(cnt8), .overflow(ovf8)
    );
    tdm_demux_check #(.ERR_CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .z(z), .in_valid(in_valid), .sync(sync), .out_ready(out_ready),
        .sel(sel2), .a_out(a2), .b_out(b2), .out_valid(ov2), .err(e2), .err_cnt(cnt2), .overflow(ovf2)
    );

    typedef struct {
        logic ar, rn, v, s, z, r;
        logic sel, a, b, ov, e;
        int   cnt;
        logic ovf;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic rn, v, s, zz, r, xsel, xa, xb, xov, xe, int xcnt, logic xovf);
        vec_t t;
        t.ar = 1'b0; t.rn = rn; t.v = v; t.s = s; t.z = zz; t.r = r;
        t.sel = xsel; t.a = xa; t.b = xb; t.ov = xov; t.e = xe; t.cnt = xcnt; t.ovf = xovf;
        return t;
    endfunction

    task automatic cmp(input string name, input int idx, input int act, input int exp);
        if (act != exp) begin
            nmis++;
            $display("FAIL row %0d %s: got %0d, want %0d", idx, name, act, exp);
        end
    endtask

    task automatic chk(input vec_t t, input int idx);
        int c2 = t.cnt > 3 ? 3 : t.cnt;
        nvec++;
        cmp("sel", idx, int'(sel8), int'(t.sel));
        cmp("out_valid", idx, int'(ov8), int'(t.ov));
        cmp("err", idx, int'(e8), int'(t.e));
        cmp("err_cnt8", idx, int'(cnt8), t.cnt);
        cmp("overflow", idx, int'(ovf8), int'(t.ovf));
        cmp("err_cnt2", idx, int'(cnt2), c2);
        cmp("err2", idx, int'(e2), int'(t.e));
        if (t.ov || !t.rn) begin
            cmp("a_out", idx, int'(a8), int'(t.a));
            cmp("b_out", idx, int'(b8), int'(t.b));
        end
    endtask

    task automatic step(input vec_t t);
        if (t.ar) begin
            #2 rst_n = 1'b0;
            #1;
        end else begin
            @(negedge clk);
            rst_n = t.rn; in_valid = t.v; sync = t.s; z = t.z; out_ready = t.r;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vec_t arow;
        // reset values, then the four OR/NOR pairs with sync on each A
        tbl.push_back(mk(0,0,0,0,1, 1,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,0,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,1,1, 1,0,1,1,0,0,0));
        tbl.push_back(mk(1,1,1,1,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,1, 1,1,0,1,0,0,0));
        tbl.push_back(mk(1,1,1,1,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,1, 1,1,0,1,0,0,0));
        tbl.push_back(mk(1,1,1,1,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,1, 1,1,0,1,0,0,0));
        tbl.push_back(mk(1,0,0,0,1, 1,0,0,0,0,0,0));
        // HUNT ignores unmarked samples; idle cycle inside SLOT_B
        tbl.push_back(mk(0,0,0,0,1, 1,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,1,1, 1,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,0,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,1,1, 1,0,1,1,0,0,0));
        tbl.push_back(mk(1,0,0,0,1, 1,0,0,0,0,0,0));
        // complement error A=B=1
        tbl.push_back(mk(1,1,1,1,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,1,1, 1,1,1,1,1,1,0));
        tbl.push_back(mk(1,0,0,0,1, 1,0,0,0,0,1,0));
        // misalignment: sync in SLOT_B replaces pending A
        tbl.push_back(mk(0,0,0,0,1, 1,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,0,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,1,1, 0,0,0,0,1,1,0));
        tbl.push_back(mk(1,1,0,0,1, 1,1,0,1,0,1,0));
        tbl.push_back(mk(1,0,0,0,1, 1,0,0,0,0,1,0));
        // backpressure: second pair (1,1) dropped without complement check
        tbl.push_back(mk(1,1,1,1,0, 0,0,0,0,0,1,0));
        tbl.push_back(mk(1,1,0,0,0, 1,1,0,1,0,1,0));
        tbl.push_back(mk(1,1,1,1,0, 0,1,0,1,0,1,0));
        tbl.push_back(mk(1,1,0,1,0, 1,1,0,1,0,1,1));
        tbl.push_back(mk(1,0,0,0,0, 1,1,0,1,0,1,1));
        tbl.push_back(mk(1,0,0,0,1, 1,0,0,0,0,1,1));
        tbl.push_back(mk(1,0,0,0,1, 1,0,0,0,0,1,1));
        // consume and load in the same cycle: no bubble
        tbl.push_back(mk(1,1,1,0,0, 0,0,0,0,0,1,1));
        tbl.push_back(mk(1,1,0,1,0, 1,0,1,1,0,1,1));
        tbl.push_back(mk(1,1,1,1,0, 0,0,1,1,0,1,1));
        tbl.push_back(mk(1,1,0,0,1, 1,1,0,1,0,1,1));
        tbl.push_back(mk(1,0,0,0,1, 1,0,0,0,0,1,1));
        // five complement errors: 2-bit counter saturates at 3, 8-bit reaches 5
        tbl.push_back(mk(0,0,0,0,1, 1,0,0,0,0,0,0));
        for (int k = 1; k <= 5; k++) begin
            tbl.push_back(mk(1,1,1,1,1, 0,0,0,0,0,k-1,0));
            tbl.push_back(mk(1,1,0,1,1, 1,1,1,1,1,k,0));
        end
        tbl.push_back(mk(1,1,1,0,0, 0,1,1,1,0,5,0));
        // asynchronous reset mid-frame with a pair held, checked before any clock edge
        arow = mk(0,0,0,0,0, 1,0,0,0,0,0,0);
        arow.ar = 1'b1;
        tbl.push_back(arow);
        // after release only a sync-marked sample restarts capture
        tbl.push_back(mk(1,1,0,1,1, 1,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,1, 1,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,0,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,1,1, 1,0,1,1,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
            chk(tbl[i], i);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
